// File: rtl/mw_adder_pkg.sv
// Shared types and constants for the multi-word adder scheduler.
package mw_adder_pkg;

  localparam int unsigned DefaultW = 8;

  typedef enum logic {
    StIdle,
    StLock
  } state_e;

  // Width of a requester index; at least one bit so ports never collapse.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mw_adder_sched_add_cin.sv
// Combinational W-bit adder with carry in and carry out; the shared datapath.
module add_cin
  import mw_adder_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Full W+1 bit sum so the carry out falls out of the top bit.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mw_adder_sched.sv
// Multi-word adder scheduler: round-robin arbitration locked per transaction,
// one shared add-with-carry datapath, carry chained across beats.
module mw_adder_sched
  import mw_adder_pkg::*;
#(
  parameter  int unsigned W    = DefaultW,
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = id_width(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_cout,
  output logic              res_last,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  state_e         state_q;
  logic [IDW-1:0] gnt_id_q;
  logic [IDW-1:0] rr_ptr_q;
  logic           first_q;
  logic           carry_q;
  logic           res_valid_q;
  logic [W-1:0]   res_sum_q;
  logic           res_cout_q;
  logic           res_last_q;
  logic [IDW-1:0] res_id_q;

  logic           arb_found;
  logic [IDW-1:0] arb_id;
  int unsigned    arb_idx;
  logic [W-1:0]   a_sel;
  logic [W-1:0]   b_sel;
  logic           valid_sel;
  logic           cin_sel;
  logic           last_sel;
  logic           slot_free;
  logic           accept;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic [IDW-1:0] rr_next;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    arb_idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found = 1'b1;
        arb_id    = IDW'(arb_idx);
      end
    end
  end

  // Steer the locked requester's beat onto the shared datapath.
  always_comb begin
    a_sel     = '0;
    b_sel     = '0;
    valid_sel = 1'b0;
    cin_sel   = 1'b0;
    last_sel  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id_q == IDW'(i)) begin
        a_sel     = req_a[i*W +: W];
        b_sel     = req_b[i*W +: W];
        valid_sel = req_valid[i];
        cin_sel   = req_cin[i];
        last_sel  = req_last[i];
      end
    end
  end

  // The result register can take a beat when empty or draining this cycle.
  assign slot_free = !res_valid_q || res_ready;
  assign accept    = (state_q == StLock) && valid_sel && slot_free;
  assign rr_next   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  // Only the locked requester ever sees ready.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == StLock) && slot_free && (gnt_id_q == IDW'(i));
    end
  end

  add_cin #(
    .W (W)
  ) u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (first_q ? cin_sel : carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Lock FSM, carry chain and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_id_q    <= '0;
      rr_ptr_q    <= '0;
      first_q     <= 1'b0;
      carry_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_last_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_found) begin
            gnt_id_q <= arb_id;
            first_q  <= 1'b1;
            state_q  <= StLock;
          end
        end
        StLock: begin
          // A dropped valid simply holds the lock and the carry.
          if (accept) begin
            carry_q <= add_cout;
            first_q <= 1'b0;
            if (last_sel) begin
              state_q  <= StIdle;
              rr_ptr_q <= rr_next;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        res_valid_q <= 1'b1;
        res_sum_q   <= add_sum;
        res_cout_q  <= add_cout;
        res_last_q  <= last_sel;
        res_id_q    <= gnt_id_q;
      end else if (res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_last  = res_last_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q == StLock);

endmodule

// File: tb/tb_mw_adder_sched.sv
// Scoreboard bench for mw_adder_sched: expected beats queued at handshake,
// compared when the result register drains.
module tb_mw_adder_sched;

  localparam int unsigned W    = 8;
  localparam int unsigned NREQ = 2;
  localparam int          Tmo  = 50;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ-1:0]   req_cin = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [W-1:0]      res_sum;
  logic              res_cout;
  logic              res_last;
  logic [0:0]        res_id;
  logic              busy;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   acc_log[$];
  int   acc_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  mw_adder_sched #(
    .W    (W),
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_last  (res_last),
    .res_id    (res_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Drive one transaction for requester id, beat k taken from av/bv[k*8 +: 8].
  // gap_after > 0 drops valid for that many cycles after the first beat.
  task automatic send(input int id, input int n, input logic [63:0] av, input logic [63:0] bv,
                      input logic cin, input int gap_after, output int wait0);
    logic       carry;
    logic       cin_eff;
    logic [8:0] tot;
    int         waited;
    carry = 1'b0;
    wait0 = -1;
    for (int k = 0; k < n; k++) begin
      if (k == 1 && gap_after > 0) begin
        req_valid[id] = 1'b0;
        repeat (gap_after) @(negedge clk);
      end
      req_valid[id]      = 1'b1;
      req_a[id*W +: W]   = av[k*8 +: 8];
      req_b[id*W +: W]   = bv[k*8 +: 8];
      req_cin[id]        = cin;
      req_last[id]       = (k == n - 1);
      waited = 0;
      #1;
      while (!req_ready[id] && waited < Tmo) begin
        @(negedge clk);
        #1;
        waited++;
      end
      if (!req_ready[id]) begin
        check_eq("ready_timeout", 32'(id), 32'hFFFF_FFFF);
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        return;
      end
      if (k == 0) wait0 = waited;
      cin_eff = (k == 0) ? cin : carry;
      tot     = {1'b0, av[k*8 +: 8]} + {1'b0, bv[k*8 +: 8]} + {8'b0, cin_eff};
      carry   = tot[8];
      sb.push_back('{sum: tot[7:0], cout: tot[8], last: (k == n - 1), id: id});
      acc_log.push_back(id);
      acc_cyc.push_back(cyc);
      @(negedge clk);
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    rst = 1'b0;
  endtask

  // Drain monitor: each handshake pops and compares the oldest expected beat.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_result", 32'(res_sum), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("res_sum", 32'(res_sum), 32'(e.sum));
        check_eq("res_cout", 32'(res_cout), 32'(e.cout));
        check_eq("res_last", 32'(res_last), 32'(e.last));
        check_eq("res_id", 32'(res_id), 32'(e.id));
      end
    end
  end

  initial begin
    int w;
    int t;
    exp_t e;
    int exp_rr[4];
    int exp_gap[3];
    exp_rr  = '{0, 1, 0, 1};
    exp_gap = '{1, 1, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'h0);
    check_eq("rst_res_valid", 32'(res_valid), 32'h0);
    check_eq("rst_res_sum", 32'(res_sum), 32'h0);
    check_eq("rst_res_cout", 32'(res_cout), 32'h0);
    check_eq("rst_res_last", 32'(res_last), 32'h0);
    check_eq("rst_res_id", 32'(res_id), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single beat with carry out, ready one cycle after valid.
    send(0, 1, 64'hFF, 64'h01, 1'b0, 0, w);
    check_eq("t1_grant_latency", 32'(w), 32'd1);
    #1;
    check_eq("t1_busy_after_last", 32'(busy), 32'h0);
    @(negedge clk);

    // 2: two-beat 16-bit carry chain on consecutive cycles.
    acc_cyc.delete();
    send(0, 2, 64'h01FF, 64'h0001, 1'b0, 0, w);
    check_eq("t2_grant_latency", 32'(w), 32'd1);
    check_eq("t2_back_to_back", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
    repeat (3) @(negedge clk);

    // 3: round-robin between two always-valid requesters.
    do_reset();
    acc_log.delete();
    acc_cyc.delete();
    fork
      begin
        send(0, 1, 64'h10, 64'h01, 1'b0, 0, w);
        send(0, 1, 64'h20, 64'h02, 1'b1, 0, w);
      end
      begin
        send(1, 1, 64'h80, 64'h80, 1'b0, 0, w);
        send(1, 1, 64'hF0, 64'h0F, 1'b1, 0, w);
      end
    join
    check_eq("t3_n_grants", 32'(acc_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++)
      check_eq("t3_grant_order", 32'(acc_log[i]), 32'(exp_rr[i]));
    for (int i = 0; i + 1 < acc_cyc.size(); i++)
      check_eq("t3_turnaround", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
    repeat (3) @(negedge clk);

    // 4: backpressure in the middle of a 3-beat transaction.
    fork
      send(0, 3, 64'hFFFFFF, 64'h000001, 1'b0, 0, w);
      begin
        t = 0;
        @(negedge clk);
        while (!res_valid && t < Tmo) begin
          @(negedge clk);
          t++;
        end
        res_ready = 1'b0;
        if (sb.size() == 0) begin
          check_eq("t4_no_expected", 32'h0, 32'h1);
        end else begin
          e = sb[0];
          repeat (3) begin
            #1;
            check_eq("t4_req_ready", 32'(req_ready), 32'h0);
            check_eq("t4_res_valid", 32'(res_valid), 32'h1);
            check_eq("t4_hold_sum", 32'(res_sum), 32'(e.sum));
            check_eq("t4_hold_cout", 32'(res_cout), 32'(e.cout));
            check_eq("t4_busy", 32'(busy), 32'h1);
            @(negedge clk);
          end
        end
        res_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);

    // 5: locked requester 1 pauses; requester 0 must wait for it.
    acc_log.delete();
    acc_cyc.delete();
    fork
      send(1, 2, 64'h00FF, 64'h0001, 1'b0, 2, w);
      begin
        repeat (2) @(negedge clk);
        send(0, 1, 64'h05, 64'h03, 1'b0, 0, w);
      end
    join
    check_eq("t5_n_grants", 32'(acc_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < acc_log.size(); i++)
      check_eq("t5_order", 32'(acc_log[i]), 32'(exp_gap[i]));
    if (acc_cyc.size() >= 2)
      check_eq("t5_gap_cycles", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    repeat (3) @(negedge clk);

    // 6: reset while the result register is full.
    res_ready = 1'b0;
    send(0, 1, 64'h55, 64'h11, 1'b0, 0, w);
    #1;
    check_eq("t6_full_before_rst", 32'(res_valid), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("t6_req_ready", 32'(req_ready), 32'h0);
    check_eq("t6_res_valid", 32'(res_valid), 32'h0);
    check_eq("t6_res_sum", 32'(res_sum), 32'h0);
    check_eq("t6_res_cout", 32'(res_cout), 32'h0);
    check_eq("t6_res_last", 32'(res_last), 32'h0);
    check_eq("t6_res_id", 32'(res_id), 32'h0);
    check_eq("t6_busy", 32'(busy), 32'h0);
    sb.delete();
    @(negedge clk);
    rst       = 1'b0;
    res_ready = 1'b1;
    send(1, 1, 64'h10, 64'h20, 1'b1, 0, w);
    if (sb.size() > 0) check_eq("t6_model_sum", 32'(sb[sb.size()-1].sum), 32'h31);

    // Everything pushed must have drained.
    t = 0;
    while (sb.size() != 0 && t < Tmo) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mw_adder_sched.md
# mw_adder_sched

Multi-word adder scheduler: shares a single W-bit add-with-carry datapath between NREQ requesters. It runs each requester's operand stream byte-serially, least-significant word first, and chains the carry across beats. It sits between the tile's input-side requesters and the `uo_out` result path. Arbitration is round-robin and locked per transaction, so carries never interleave between requesters.

## Interface
Parameters:
- `W`, 8, operand/sum word width
- `NREQ`, 2, number of requesters (≥2); `IDW = $clog2(NREQ)`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  per-requester beat valid
- `req_a`  in  NREQ*W  operand A word, requester i at bits [i*W +: W]
- `req_b`  in  NREQ*W  operand B word, same packing
- `req_cin`  in  NREQ  carry-in; sampled only on a transaction's first beat
- `req_last`  in  NREQ  marks the final (most-significant) beat
- `req_ready`  out  NREQ  one-hot or zero; a beat transfers on valid&ready
- `res_valid`  out  1  result word valid
- `res_ready`  in  1  downstream accepts result
- `res_sum`  out  W  sum word
- `res_cout`  out  1  carry out of this beat
- `res_last`  out  1  copy of `req_last` for this beat
- `res_id`  out  IDW  requester that produced this beat
- `busy`  out  1  high while a transaction is locked

## Operation
- States: IDLE and LOCK.
- **IDLE:**
  - If any `req_valid`, grant the first asserted index at or after `rr_ptr`, wrapping.
  - Register `gnt_id`, set `first=1`, go to LOCK.
  - No beat is accepted in IDLE.
- **LOCK:**
  - `req_ready[gnt_id] = !res_valid || res_ready`. All other ready bits are 0.
  - On accept, compute `{cout,sum} = a + b + (first ? req_cin : carry_q)` at W+1 bits.
  - Load the result register (sum, cout, last, id) and set `res_valid`.
  - Update `carry_q = cout` and clear `first`.
- **Last beat:**
  - When the accepted beat has `req_last=1`: go to IDLE and set `rr_ptr = gnt_id+1`, wrapping at NREQ.
  - `carry_q` is don't-care after the last beat; the next transaction uses its own `req_cin`.
- **Granted requester drops valid mid-transaction:**
  - The lock is held and `carry_q` is held.
  - Other requesters are not served.
  - No timeout.
- **Result register:**
  - Clears `res_valid` on `res_valid && res_ready` with no new accept in the same cycle.
  - A simultaneous drain and accept reloads the register with no bubble.
- **Held output:** while `res_valid && !res_ready`, all `res_*` outputs are stable.
- **Single-beat transaction:** a beat with `first=1` and `last=1` is legal.

## Timing
- **Reset values:**
  - `req_ready` = 0, `res_valid` = 0, `res_sum` = 0, `res_cout` = 0, `res_last` = 0, `res_id` = 0, `busy` = 0.
  - Internal: `rr_ptr` = 0, `carry_q` = 0, state IDLE.
- **Reset mid-transaction:** aborts and drops any pending result. Nothing is emitted afterwards for that transaction.
- **Arbitration latency:** `req_valid` seen in IDLE at cycle T → LOCK with ready asserted at T+1.
- **Result latency:** beat accepted at T → `res_valid` with its result at T+1.
- **Throughput:** 1 beat/cycle with `res_ready` held high.
- **Turnaround:** last beat at T → IDLE at T+1 → next grant's ready at T+2. This gives one dead cycle between transactions.
- **Busy:** `busy` = (state == LOCK).

## Structure
- **Shared package `mw_adder_pkg`:**
  - state enum {IDLE, LOCK}
  - default `W`
  - `IDW` helper function
- **Sub-module `add_cin`:** purely combinational W-bit adder with carry (`a`, `b`, `cin` → `sum`, `cout`). It is the shared datapath, instantiated once.
- **Top-level logic:** arbiter, lock FSM and result register live in `mw_adder_sched`.

## Test plan
1. **Single beat, carry out:** after reset, req0 sends a=0xFF, b=0x01, cin=0, last=1.
   - ready0 high at cycle 1.
   - Next cycle: sum=0x00, cout=1, last=1, id=0.
2. **Two-beat 16-bit carry chain:** 0x01FF + 0x0001 as beats (FF,01,cin=0) then (01,00,last).
   - Beat 0: sum=0x00, cout=1.
   - Beat 1: sum=0x02, cout=0.
   - Consecutive cycles.
3. **Round-robin:** req0 and req1 both hold valid with continuous single-beat transactions.
   - Grants go 0,1,0,1.
   - One idle cycle between results.
   - req1 never receives ready while req0 is locked.
4. **Backpressure:** `res_ready=0` for 3 cycles during a 3-beat transaction.
   - `req_ready` low and `res_*` stable for those cycles.
   - `carry_q` is preserved, e.g. 0xFFFFFF + 0x000001 still yields 00,00,00 with final cout=1.
5. **Valid gap:** granted req1 drops valid for 2 cycles mid-transaction while req0 is valid.
   - req0 is not served.
   - req1's resumed beat uses the held carry.
6. **Reset mid-transaction:** assert `rst` while the result register is full.
   - All outputs zero next cycle.
   - The following transaction from req1 uses its own cin=1: 0x10+0x20 → sum=0x31.
